mcu_readback: RTL and testbench

MCU_READBACK -- requirements
Module: mcu_readback

---
 rtl/mcu_readback.sv | 150 +++++++++++++++
 tb/tb_mcu_readback.sv | 289 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mcu_readback.sv
// Streams a block of memory words to a host through a 2-entry FIFO with valid/ready handshake.
// Optional macro MCU_READBACK_PARITY_EN appends an even-parity bit above the pixel word.
module mcu_readback #(
    parameter int unsigned N           = 2,
    parameter int unsigned BITS_IMAGEN = 8,
    parameter int unsigned ADDR_WIDTH  = 10
) (
    input  logic                       i_CLK,
    input  logic                       i_Reset,
    input  logic                       i_Start,
    input  logic                       i_Abort,
    input  logic [ADDR_WIDTH-1:0]      i_BaseAddr,
    input  logic [ADDR_WIDTH-1:0]      i_Length,
    output logic                       o_RdEn,
    output logic [ADDR_WIDTH-1:0]      o_RdAddr,
    input  logic [N*BITS_IMAGEN-1:0]   i_MemWord,
    output logic [3*BITS_IMAGEN-1:0]   o_Data,
    output logic                       o_Valid,
    input  logic                       i_Ready,
    output logic                       o_Busy,
    output logic                       o_Done
);

    localparam int unsigned W  = N * BITS_IMAGEN;
    localparam int unsigned OW = 3 * BITS_IMAGEN;
`ifdef MCU_READBACK_PARITY_EN
    localparam int unsigned EW = W + 1;
`else
    localparam int unsigned EW = W;
`endif

    typedef enum logic [1:0] {StIdle, StRead, StDone} state_e;

    state_e                state_q;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] len_q;
    logic [ADDR_WIDTH-1:0] issued_q;
    logic [ADDR_WIDTH-1:0] xfer_q;
    logic [1:0]            count_q;
    logic                  inflight_q;
    logic [EW-1:0]         head_q;
    logic [EW-1:0]         tail_q;

    logic                  pop;
    logic                  push;
    logic [2:0]            occ;
    logic                  rd_en;
    logic [EW-1:0]         wr_entry;
    logic [OW-1:0]         data_full;

    assign pop  = (count_q != 2'd0) && i_Ready;
    assign push = inflight_q;

    // Occupancy the FIFO will need once every outstanding read has landed.
    assign occ = {1'b0, count_q} + {2'b00, inflight_q} - {2'b00, pop};

    assign rd_en = (state_q == StRead) && (issued_q < len_q) && (occ < 3'd2) && !i_Abort;

`ifdef MCU_READBACK_PARITY_EN
    assign wr_entry = {^i_MemWord, i_MemWord};
`else
    assign wr_entry = i_MemWord;
`endif

    always_comb begin
        data_full           = '0;
        data_full[EW-1:0]   = head_q;
    end

    always_comb begin
        o_RdEn   = rd_en && !i_Reset;
        o_RdAddr = i_Reset ? '0 : (base_q + issued_q);
        o_Data   = i_Reset ? '0 : data_full;
        o_Valid  = (count_q != 2'd0) && !i_Reset;
        o_Busy   = (state_q != StIdle) && !i_Reset;
        o_Done   = (state_q == StDone) && !i_Reset && !i_Abort;
    end

    always_ff @(posedge i_CLK) begin
        if (i_Reset || i_Abort) begin
            // Abort and reset both drop buffered and in-flight data on the floor.
            state_q    <= StIdle;
            base_q     <= '0;
            len_q      <= '0;
            issued_q   <= '0;
            xfer_q     <= '0;
            count_q    <= 2'd0;
            inflight_q <= 1'b0;
            head_q     <= '0;
            tail_q     <= '0;
        end else begin
            inflight_q <= rd_en;
            if (rd_en) begin
                issued_q <= issued_q + ADDR_WIDTH'(1);
            end
            if (pop) begin
                xfer_q <= xfer_q + ADDR_WIDTH'(1);
            end

            unique case ({push, pop})
                2'b10: begin
                    if (count_q == 2'd0) begin
                        head_q <= wr_entry;
                    end else begin
                        tail_q <= wr_entry;
                    end
                    count_q <= count_q + 2'd1;
                end
                2'b01: begin
                    head_q  <= tail_q;
                    count_q <= count_q - 2'd1;
                end
                2'b11: begin
                    if (count_q == 2'd1) begin
                        head_q <= wr_entry;
                    end else begin
                        head_q <= tail_q;
                        tail_q <= wr_entry;
                    end
                end
                default: begin
                end
            endcase

            case (state_q)
                StIdle: begin
                    if (i_Start) begin
                        base_q   <= i_BaseAddr;
                        len_q    <= i_Length;
                        issued_q <= '0;
                        xfer_q   <= '0;
                        state_q  <= (i_Length != '0) ? StRead : StDone;
                    end
                end
                StRead: begin
                    if (pop && (xfer_q + ADDR_WIDTH'(1) == len_q)) begin
                        state_q <= StDone;
                    end
                end
                StDone: begin
                    state_q <= StIdle;
                end
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mcu_readback.sv
// Directed bench for mcu_readback: address/data scoreboards checked by a negedge monitor.
module tb_mcu_readback;

    localparam int unsigned N  = 2;
    localparam int unsigned B  = 8;
    localparam int unsigned AW = 10;
    localparam int unsigned W  = N * B;
    localparam int unsigned OW = 3 * B;

    logic          i_CLK = 1'b0;
    logic          i_Reset = 1'b1;
    logic          i_Start = 1'b0;
    logic          i_Abort = 1'b0;
    logic          i_Ready = 1'b1;
    logic [AW-1:0] i_BaseAddr = '0;
    logic [AW-1:0] i_Length = '0;
    logic [W-1:0]  i_MemWord = '0;
    logic          o_RdEn;
    logic [AW-1:0] o_RdAddr;
    logic [OW-1:0] o_Data;
    logic          o_Valid;
    logic          o_Busy;
    logic          o_Done;

    mcu_readback #(
        .N           (N),
        .BITS_IMAGEN (B),
        .ADDR_WIDTH  (AW)
    ) dut (
        .i_CLK      (i_CLK),
        .i_Reset    (i_Reset),
        .i_Start    (i_Start),
        .i_Abort    (i_Abort),
        .i_BaseAddr (i_BaseAddr),
        .i_Length   (i_Length),
        .o_RdEn     (o_RdEn),
        .o_RdAddr   (o_RdAddr),
        .i_MemWord  (i_MemWord),
        .o_Data     (o_Data),
        .o_Valid    (o_Valid),
        .i_Ready    (i_Ready),
        .o_Busy     (o_Busy),
        .o_Done     (o_Done)
    );

    always #5 i_CLK = ~i_CLK;

    int cyc = 0;
    always @(posedge i_CLK) cyc <= cyc + 1;

    // Memory model: one-cycle read latency, junk whenever no read was issued.
    logic [W-1:0] mem_xor = 16'h5A5A;
    always @(posedge i_CLK) i_MemWord <= o_RdEn ? (W'(o_RdAddr) ^ mem_xor) : 16'hDEAD;

    int n_checks = 0;
    int n_errors = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [OW-1:0] exp_word(input logic [AW-1:0] a);
        logic [W-1:0]  w;
        logic [OW-1:0] r;
        w = W'(a) ^ mem_xor;
        r = '0;
        r[W-1:0] = w;
`ifdef MCU_READBACK_PARITY_EN
        r[W] = ^w;
`endif
        return r;
    endfunction

    logic [AW-1:0] exp_addr[$];
    logic [OW-1:0] exp_data[$];

    int rd_cnt, xfer_cnt, valid_cnt, done_cnt;
    int first_rd, last_rd, first_valid, first_xfer, last_xfer, done_cyc;
    int t_start;

    task automatic clear_stats();
        rd_cnt = 0; xfer_cnt = 0; valid_cnt = 0; done_cnt = 0;
        first_rd = -1; last_rd = -1; first_valid = -1;
        first_xfer = -1; last_xfer = -1; done_cyc = -1;
    endtask

    always @(negedge i_CLK) begin
        if (!i_Reset) begin
            if (o_Valid) begin
                valid_cnt++;
                if (first_valid < 0) first_valid = cyc;
            end
            if (o_RdEn) begin
                chk("rd_expected", exp_addr.size() != 0, 1);
                if (exp_addr.size() != 0) chk("rd_addr", o_RdAddr, exp_addr.pop_front());
                rd_cnt++;
                if (first_rd < 0) first_rd = cyc;
                last_rd = cyc;
            end
            if (o_Valid && i_Ready) begin
                chk("xfer_expected", exp_data.size() != 0, 1);
                if (exp_data.size() != 0) chk("xfer_data", o_Data, exp_data.pop_front());
                xfer_cnt++;
                if (first_xfer < 0) first_xfer = cyc;
                last_xfer = cyc;
            end
            if (o_Done) begin
                done_cnt++;
                done_cyc = cyc;
            end
        end
    end

    task automatic start(input logic [AW-1:0] base, input logic [AW-1:0] len);
        for (int i = 0; i < int'(len); i++) begin
            logic [AW-1:0] a;
            a = base + AW'(i);
            exp_addr.push_back(a);
            exp_data.push_back(exp_word(a));
        end
        @(posedge i_CLK); #1;
        i_BaseAddr = base;
        i_Length   = len;
        i_Start    = 1'b1;
        t_start    = cyc;
        @(posedge i_CLK); #1;
        i_Start = 1'b0;
    endtask

    task automatic wait_done(input int bound);
        int n;
        n = 0;
        while (done_cnt == 0 && n < bound) begin
            @(posedge i_CLK); #1;
            n++;
        end
        chk("done_seen", done_cnt != 0, 1);
        repeat (2) @(posedge i_CLK);
        #1;
    endtask

    initial begin
        int n;
        int v0;
        logic [OW-1:0] held;

        clear_stats();
        repeat (3) @(posedge i_CLK);
        #1;
        chk("reset_flags", {o_RdEn, o_Valid, o_Busy, o_Done}, 0);
        chk("reset_addr", o_RdAddr, 0);
        chk("reset_data", o_Data, 0);
        i_Reset = 1'b0;
        repeat (2) @(posedge i_CLK);
        #1;

        // Basic streaming run with host always ready.
        clear_stats();
        start(10'h010, 10'd4);
        wait_done(40);
        chk("a_first_rd", first_rd, t_start + 1);
        chk("a_rd_cnt", rd_cnt, 4);
        chk("a_rd_span", last_rd - first_rd, 3);
        chk("a_valid_lat", first_valid - first_rd, 2);
        chk("a_xfer_cnt", xfer_cnt, 4);
        chk("a_xfer_span", last_xfer - first_xfer, 3);
        chk("a_done_cnt", done_cnt, 1);
        chk("a_done_cyc", done_cyc, last_xfer + 1);
        chk("a_sb_empty", exp_data.size(), 0);

        // Host back-pressure: reads stall at two outstanding, head word held.
        clear_stats();
        i_Ready = 1'b0;
        start(10'h100, 10'd3);
        n = 0;
        while (!o_Valid && n < 20) begin
            @(posedge i_CLK); #1;
            n++;
        end
        chk("b_valid_seen", o_Valid, 1);
        held = o_Data;
        chk("b_stall_rd", rd_cnt, 2);
        for (int i = 0; i < 5; i++) begin
            chk("b_hold", {o_Valid, o_Data}, {1'b1, held});
            @(posedge i_CLK); #1;
        end
        chk("b_stall_rd_after", rd_cnt, 2);
        i_Ready = 1'b1;
        wait_done(40);
        chk("b_rd_cnt", rd_cnt, 3);
        chk("b_xfer_cnt", xfer_cnt, 3);
        chk("b_done_cnt", done_cnt, 1);
        chk("b_valid_lat", first_valid - first_rd, 2);

        // Address wrap past the top of memory.
        clear_stats();
        start(10'h3FE, 10'd4);
        wait_done(40);
        chk("c_rd_cnt", rd_cnt, 4);
        chk("c_xfer_cnt", xfer_cnt, 4);
        chk("c_done_cnt", done_cnt, 1);

        // Zero-length request.
        clear_stats();
        start(10'h055, 10'd0);
        chk("d_done", o_Done, 1);
        chk("d_busy", o_Busy, 1);
        @(posedge i_CLK); #1;
        chk("d_idle", {o_Done, o_Busy}, 0);
        repeat (3) @(posedge i_CLK);
        #1;
        chk("d_rd_cnt", rd_cnt, 0);
        chk("d_valid_cnt", valid_cnt, 0);
        chk("d_done_cnt", done_cnt, 1);

        // Abort after two transfers, then a fresh run.
        clear_stats();
        start(10'h200, 10'd6);
        n = 0;
        while (xfer_cnt < 2 && n < 40) begin
            @(posedge i_CLK); #1;
            n++;
        end
        chk("e_two_xfers", xfer_cnt, 2);
        i_Abort = 1'b1;
        i_Ready = 1'b0;
        exp_addr.delete();
        exp_data.delete();
        @(posedge i_CLK); #1;
        i_Abort = 1'b0;
        chk("e_valid_low", o_Valid, 0);
        chk("e_busy_low", o_Busy, 0);
        v0 = valid_cnt;
        i_Ready = 1'b1;
        repeat (4) @(posedge i_CLK);
        #1;
        chk("e_no_valid", valid_cnt, v0);
        chk("e_no_done", done_cnt, 0);
        chk("e_xfer_cnt", xfer_cnt, 2);
        clear_stats();
        start(10'h020, 10'd2);
        wait_done(40);
        chk("e2_xfer_cnt", xfer_cnt, 2);
        chk("e2_done_cnt", done_cnt, 1);

        // Single word 0x0107: upper host bits carry only the optional parity.
        clear_stats();
        mem_xor = 16'h0107;
        start(10'h000, 10'd1);
        wait_done(40);
        chk("f_xfer_cnt", xfer_cnt, 1);
        mem_xor = 16'h5A5A;

        // Reset in the middle of a readback discards everything.
        clear_stats();
        start(10'h300, 10'd4);
        @(posedge i_CLK); #1;
        i_Reset = 1'b1;
        exp_addr.delete();
        exp_data.delete();
        #1;
        chk("g_reset_flags", {o_RdEn, o_Valid, o_Busy, o_Done}, 0);
        chk("g_reset_addr", o_RdAddr, 0);
        chk("g_reset_data", o_Data, 0);
        @(posedge i_CLK); #1;
        i_Reset = 1'b0;
        v0 = valid_cnt;
        repeat (4) @(posedge i_CLK);
        #1;
        chk("g_no_valid", valid_cnt, v0);
        chk("g_no_xfer", xfer_cnt, 0);
        chk("g_busy_low", o_Busy, 0);
        chk("g_no_done", done_cnt, 0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete, observed timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
